// File: rtl/liteeth_sram_rw_arbiter_if.sv
// Purpose: one requester's request/response channel into the SRAM rw0 arbiter.
// Latency: request accepted on req_valid & req_ready; rsp_valid pulses exactly one cycle later.
// Backpressure: the requester holds every req_* field stable while req_valid=1 and req_ready=0.
// Ports (master = requester side):
//   req_valid/req_ready  handshake
//   req_we               1=write, 0=read
//   req_addr             word address
//   req_wdata            write data
//   req_wmask            byte enables; bit k covers [8k+7:8k]
//   rsp_valid            one-cycle completion pulse
//   rsp_err              address was out of range (qualified by rsp_valid)
//   rsp_rdata            read data (qualified by rsp_valid)
interface liteeth_sram_rw_arbiter_if #(
    parameter int BITS       = 32,
    parameter int ADDR_WIDTH = 9
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata;
    logic [3:0]            req_wmask;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [BITS-1:0]       rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wmask,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wmask,
        output req_ready, rsp_valid, rsp_err, rsp_rdata
    );
endinterface

// File: rtl/liteeth_sram_rw_arbiter.sv
// Purpose: round-robin arbiter sharing the rw0 port of the 32x384 packet-buffer SRAM between m0 and m1.
// Latency: SRAM access issued in the handshake cycle; response (rdata/err) one cycle later, 1 transfer/cycle.
// Backpressure: req_ready is combinational from the valids and arbiter state; the loser simply waits.
// Ports:
//   clk, rst         single clock (also the SRAM rw0 clock), asynchronous active-high reset
//   m0, m1           requester channels (slave side of liteeth_sram_rw_arbiter_if)
//   sram_ce/we/addr/wd/wmask  to the SRAM rw0 inputs; all forced to 0 whenever ce=0
//   sram_rd          rw0 read data, valid the cycle after a read is issued
module liteeth_sram_rw_arbiter #(
    parameter int BITS       = 32,     // fixed at 32: the byte mask is 4 bits wide
    parameter int WORD_DEPTH = 384,
    parameter int ADDR_WIDTH = 9,
    parameter int MAX_BURST  = 4       // must be >= 1
) (
    input  logic                  clk,
    input  logic                  rst,
    liteeth_sram_rw_arbiter_if.slave m0,
    liteeth_sram_rw_arbiter_if.slave m1,
    output logic                  sram_ce,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [BITS-1:0]       sram_wd,
    output logic [3:0]            sram_wmask,
    input  logic [BITS-1:0]       sram_rd
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_BURST);
    // One extra bit so a WORD_DEPTH of 2**ADDR_WIDTH does not wrap to 0.
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(WORD_DEPTH);

    typedef enum logic {
        REQ_M0 = 1'b0,
        REQ_M1 = 1'b1
    } req_id_e;

    req_id_e       owner;
    logic [CW-1:0] burst_cnt;

    req_id_e               sel;
    logic                  gnt;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [BITS-1:0]       req_wdata;
    logic [3:0]            req_wmask;
    logic                  in_range;
    logic                  issue;
    logic                  hs0;
    logic                  hs1;

    // Response stage registers
    logic rsp_vld0, rsp_err0, rd_pend0;
    logic rsp_vld1, rsp_err1, rd_pend1;

    // Grant selection. Nothing is granted while rst is high, so a transfer
    // can never be accepted (and never produce a response) during reset.
    always_comb begin
        sel = owner;
        gnt = 1'b0;
        if (!rst) begin
            if (m0.req_valid && m1.req_valid) begin
                gnt = 1'b1;
                // Stay with the owner only mid-burst; a fresh (cnt=0) or
                // exhausted (cnt=MAX) burst hands the port to the other side.
                if (burst_cnt != '0 && burst_cnt < MAX_C)
                    sel = owner;
                else
                    sel = (owner == REQ_M0) ? REQ_M1 : REQ_M0;
            end else if (m0.req_valid) begin
                gnt = 1'b1;
                sel = REQ_M0;
            end else if (m1.req_valid) begin
                gnt = 1'b1;
                sel = REQ_M1;
            end
        end
    end

    assign hs0 = gnt && (sel == REQ_M0);
    assign hs1 = gnt && (sel == REQ_M1);

    assign m0.req_ready = hs0;
    assign m1.req_ready = hs1;

    // Field mux from the selected requester
    assign req_we    = (sel == REQ_M1) ? m1.req_we    : m0.req_we;
    assign req_addr  = (sel == REQ_M1) ? m1.req_addr  : m0.req_addr;
    assign req_wdata = (sel == REQ_M1) ? m1.req_wdata : m0.req_wdata;
    assign req_wmask = (sel == REQ_M1) ? m1.req_wmask : m0.req_wmask;

    assign in_range = ({1'b0, req_addr} < DEPTH_L);
    // gnt is evaluated first so an idle cycle with X request fields still
    // yields a clean 0 on ce.
    assign issue    = gnt && in_range;

    // Every SRAM control is zeroed when ce is low: an X on we/addr can
    // corrupt the whole array in the macro model.
    assign sram_ce    = issue;
    assign sram_we    = issue ? req_we    : 1'b0;
    assign sram_addr  = issue ? req_addr  : '0;
    assign sram_wd    = issue ? req_wdata : '0;
    assign sram_wmask = issue ? req_wmask : '0;

    // Arbiter state and response stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= REQ_M0;
            burst_cnt <= '0;
            rsp_vld0  <= 1'b0;
            rsp_err0  <= 1'b0;
            rd_pend0  <= 1'b0;
            rsp_vld1  <= 1'b0;
            rsp_err1  <= 1'b0;
            rd_pend1  <= 1'b0;
        end else begin
            if (!gnt) begin
                burst_cnt <= '0;
            end else if (sel == owner) begin
                if (burst_cnt != MAX_C)
                    burst_cnt <= burst_cnt + 1'b1;
            end else begin
                owner     <= sel;
                burst_cnt <= CW'(1);
            end

            rsp_vld0 <= hs0;
            rsp_err0 <= hs0 && !in_range;
            rd_pend0 <= hs0 && in_range && !req_we;
            rsp_vld1 <= hs1;
            rsp_err1 <= hs1 && !in_range;
            rd_pend1 <= hs1 && in_range && !req_we;
        end
    end

    // Read data comes straight from the SRAM output register; writes and
    // dropped requests return 0.
    assign m0.rsp_valid = rsp_vld0;
    assign m0.rsp_err   = rsp_err0;
    assign m0.rsp_rdata = rd_pend0 ? sram_rd : '0;
    assign m1.rsp_valid = rsp_vld1;
    assign m1.rsp_err   = rsp_err1;
    assign m1.rsp_rdata = rd_pend1 ? sram_rd : '0;

endmodule

// File: tb/tb_liteeth_sram_rw_arbiter.sv
// Purpose: directed self-checking bench for liteeth_sram_rw_arbiter with a read-first, byte-masked SRAM model.
// Latency: inputs driven 1 ns after posedge; combinational outputs checked 1 ns later, responses 1 ns after the next posedge.
// Backpressure: requests are held until the bench has seen the expected ready.
module tb_liteeth_sram_rw_arbiter;

    logic        clk;
    logic        rst;
    logic        sram_ce;
    logic        sram_we;
    logic [8:0]  sram_addr;
    logic [31:0] sram_wd;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_rd;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] mem [0:383];

    liteeth_sram_rw_arbiter_if #(.BITS(32), .ADDR_WIDTH(9)) m0_if ();
    liteeth_sram_rw_arbiter_if #(.BITS(32), .ADDR_WIDTH(9)) m1_if ();

    liteeth_sram_rw_arbiter #(
        .BITS(32), .WORD_DEPTH(384), .ADDR_WIDTH(9), .MAX_BURST(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .m0         (m0_if.slave),
        .m1         (m1_if.slave),
        .sram_ce    (sram_ce),
        .sram_we    (sram_we),
        .sram_addr  (sram_addr),
        .sram_wd    (sram_wd),
        .sram_wmask (sram_wmask),
        .sram_rd    (sram_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM rw0 model: registered read, read-first, byte-masked write
    always @(posedge clk) begin
        if (sram_ce === 1'b1) begin
            if (sram_we === 1'b1) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_wd[8*b +: 8];
            end else begin
                sram_rd <= mem[sram_addr];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int m, input logic v, input logic we,
                         input logic [8:0] addr, input logic [31:0] wd, input logic [3:0] wm);
        if (m == 0) begin
            m0_if.req_valid = v;  m0_if.req_we = we; m0_if.req_addr = addr;
            m0_if.req_wdata = wd; m0_if.req_wmask = wm;
        end else begin
            m1_if.req_valid = v;  m1_if.req_we = we; m1_if.req_addr = addr;
            m1_if.req_wdata = wd; m1_if.req_wmask = wm;
        end
    endtask

    initial begin
        logic exp1;
        for (int i = 0; i < 384; i++) mem[i] = 32'h0;
        mem[5]   = 32'hDEADBEEF;
        mem[9]   = 32'hAAAAAAAA;
        mem[127] = 32'h12345678;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);

        // Reset state
        #2;
        chk("rst_rsp0_valid", m0_if.rsp_valid, 1'b0);
        chk("rst_rsp1_valid", m1_if.rsp_valid, 1'b0);
        chk("rst_ce", sram_ce, 1'b0);
        m0_if.req_valid = 1'b1;
        m1_if.req_valid = 1'b1;
        #1;
        chk("rst_ready0_masked", m0_if.req_ready, 1'b0);
        chk("rst_ready1_masked", m1_if.req_ready, 1'b0);
        chk("rst_ce_masked", sram_ce, 1'b0);
        m0_if.req_valid = 1'b0;
        m1_if.req_valid = 1'b0;
        tick();
        rst = 1'b0;

        // Single read of preloaded word
        drive(0, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
        #1;
        chk("rd_ready0", m0_if.req_ready, 1'b1);
        chk("rd_ready1", m1_if.req_ready, 1'b0);
        chk("rd_ce", sram_ce, 1'b1);
        chk("rd_we", sram_we, 1'b0);
        chk("rd_addr", sram_addr, 9'd5);
        tick();
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("rd_rsp0_valid", m0_if.rsp_valid, 1'b1);
        chk("rd_rsp0_rdata", m0_if.rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp0_err", m0_if.rsp_err, 1'b0);
        chk("rd_rsp1_quiet", m1_if.rsp_valid, 1'b0);

        // Byte-masked write then back-to-back read
        drive(1, 1'b1, 1'b1, 9'd9, 32'h11223344, 4'b0101);
        #1;
        chk("wr_ready1", m1_if.req_ready, 1'b1);
        chk("wr_ce", sram_ce, 1'b1);
        chk("wr_we", sram_we, 1'b1);
        chk("wr_wd", sram_wd, 32'h11223344);
        chk("wr_wmask", sram_wmask, 4'b0101);
        tick();
        chk("wr_rsp1_valid", m1_if.rsp_valid, 1'b1);
        chk("wr_rsp1_rdata", m1_if.rsp_rdata, 32'h0);
        drive(1, 1'b1, 1'b0, 9'd9, 32'h0, 4'h0);
        #1;
        chk("rb_ready1", m1_if.req_ready, 1'b1);
        tick();
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("rb_rsp1_valid", m1_if.rsp_valid, 1'b1);
        chk("rb_rsp1_rdata", m1_if.rsp_rdata, 32'hAA22AA44);

        // Write with wmask=0 still issues and completes, memory unchanged
        drive(0, 1'b1, 1'b1, 9'd9, 32'hFFFFFFFF, 4'h0);
        #1;
        chk("wm0_ce", sram_ce, 1'b1);
        chk("wm0_we", sram_we, 1'b1);
        chk("wm0_wmask", sram_wmask, 4'h0);
        tick();
        chk("wm0_rsp0_valid", m0_if.rsp_valid, 1'b1);
        drive(0, 1'b1, 1'b0, 9'd9, 32'h0, 4'h0);
        tick();
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("wm0_readback", m0_if.rsp_rdata, 32'hAA22AA44);

        // Out-of-range read (m0) and write (m1)
        drive(0, 1'b1, 1'b0, 9'd384, 32'h0, 4'h0);
        #1;
        chk("oor_rd_ready0", m0_if.req_ready, 1'b1);
        chk("oor_rd_ce", sram_ce, 1'b0);
        chk("oor_rd_addr", sram_addr, 9'd0);
        tick();
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("oor_rd_rsp_valid", m0_if.rsp_valid, 1'b1);
        chk("oor_rd_rsp_err", m0_if.rsp_err, 1'b1);
        chk("oor_rd_rsp_rdata", m0_if.rsp_rdata, 32'h0);
        drive(1, 1'b1, 1'b1, 9'd511, 32'hFFFFFFFF, 4'hF);
        #1;
        chk("oor_wr_ready1", m1_if.req_ready, 1'b1);
        chk("oor_wr_ce", sram_ce, 1'b0);
        chk("oor_wr_we", sram_we, 1'b0);
        chk("oor_wr_addr", sram_addr, 9'd0);
        chk("oor_wr_wd", sram_wd, 32'h0);
        tick();
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("oor_wr_rsp_valid", m1_if.rsp_valid, 1'b1);
        chk("oor_wr_rsp_err", m1_if.rsp_err, 1'b1);
        chk("oor_wr_rsp_rdata", m1_if.rsp_rdata, 32'h0);
        chk("oor_mem127", mem[127], 32'h12345678);
        chk("oor_mem0", mem[0], 32'h0);

        // Idle with X request fields
        drive(0, 1'b0, 1'bx, 9'bx, 32'bx, 4'bx);
        drive(1, 1'b0, 1'bx, 9'bx, 32'bx, 4'bx);
        #1;
        chk("idle_ce", sram_ce, 1'b0);
        chk("idle_we", sram_we, 1'b0);
        chk("idle_addr", sram_addr, 9'd0);
        chk("idle_wd", sram_wd, 32'h0);
        chk("idle_wmask", sram_wmask, 4'h0);
        tick();
        drive(0, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
        #1;
        chk("idle_next_ready0", m0_if.req_ready, 1'b1);
        chk("idle_next_addr", sram_addr, 9'd5);
        tick();
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        chk("idle_next_rdata", m0_if.rsp_rdata, 32'hDEADBEEF);

        // Bursts: both valid from reset release -> m1 x4, m0 x4, m1 x4
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
        drive(1, 1'b1, 1'b0, 9'd9, 32'h0, 4'h0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp1 = ((i / 4) % 2) == 0;
            #1;
            chk($sformatf("burst%0d_ready1", i), m1_if.req_ready, exp1);
            chk($sformatf("burst%0d_ready0", i), m0_if.req_ready, !exp1);
            tick();
            chk($sformatf("burst%0d_rsp1", i), m1_if.rsp_valid, exp1);
            chk($sformatf("burst%0d_rsp0", i), m0_if.rsp_valid, !exp1);
            chk($sformatf("burst%0d_rdata", i),
                exp1 ? m1_if.rsp_rdata : m0_if.rsp_rdata,
                exp1 ? 32'hAA22AA44 : 32'hDEADBEEF);
        end

        // Reset asserted in the cycle of m1's second grant
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        tick();
        drive(1, 1'b1, 1'b0, 9'd9, 32'h0, 4'h0);
        #1;
        chk("mid_grant1", m1_if.req_ready, 1'b1);
        tick();
        chk("mid_rsp_first", m1_if.rsp_valid, 1'b1);
        chk("mid_grant2", m1_if.req_ready, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_cleared", m1_if.rsp_valid, 1'b0);
        chk("mid_ready_in_rst", m1_if.req_ready, 1'b0);
        chk("mid_ce_in_rst", sram_ce, 1'b0);
        tick();
        chk("mid_no_late_rsp", m1_if.rsp_valid, 1'b0);
        drive(0, 1'b1, 1'b0, 9'd5, 32'h0, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp1 = (i < 4);
            #1;
            chk($sformatf("post%0d_ready1", i), m1_if.req_ready, exp1);
            chk($sformatf("post%0d_ready0", i), m0_if.req_ready, !exp1);
            tick();
            chk($sformatf("post%0d_rsp1", i), m1_if.rsp_valid, exp1);
        end
        drive(0, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        drive(1, 1'b0, 1'b0, 9'd0, 32'h0, 4'h0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
